// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter
//
// Round-robin scheduler sharing one SPI master between NUM_CH DAC channel
// controllers. Each channel latches its own request (start + frame data);
// the arbiter serialises pending requests onto the SPI master, routes the
// master's state back to the owning channel, pulses a per-channel done, and
// holds the bus idle for GAP_CYCLES between frames. A global interlock
// flushes all pending requests and blocks new launches while an in-flight
// frame is allowed to finish.
//
// Optional feature: define DAC_ARB_TIMEOUT_EN to compile in a WAIT_DONE
// watchdog that abandons a frame after TIMEOUT_CYCLES and pulses o_timeout.
// Without the macro, o_timeout is constant low and WAIT_DONE waits forever.
//
// Reset is synchronous and active-low (i_fRST sampled at the rising edge).

module dac_spi_arbiter #(
  parameter int DATA_WIDTH     = 24,
  parameter int NUM_CH         = 4,
  parameter int GAP_CYCLES     = 30,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                         i_clk,
  input  logic                         i_fRST,
  input  logic [NUM_CH-1:0]            i_req_start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_CH*3-1:0]          o_req_state,
  output logic [NUM_CH-1:0]            o_req_done,
  input  logic                         i_interlock,
  output logic                         o_spi_start,
  output logic [DATA_WIDTH-1:0]        o_spi_data,
  input  logic [2:0]                   i_spi_state,
  output logic [NUM_CH-1:0]            o_grant,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int IDX_W = $clog2(NUM_CH);

  // SPI master state encodings that matter to the arbiter.
  localparam logic [2:0] SPI_IDLE = 3'd0;
  localparam logic [2:0] SPI_DONE = 3'd4;

  // Arbiter FSM encoding.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  logic [1:0]            state;
  logic [NUM_CH-1:0]     pending;
  logic [DATA_WIDTH-1:0] data_q [NUM_CH];
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      owner;
  logic                  busy_seen;
  logic [7:0]            gap_cnt;

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [NUM_CH-1:0]     sel_onehot;
  logic                  launch_go;
  logic [NUM_CH-1:0]     clr_mask;
  logic                  done_hit;
  logic                  timeout_hit;
  logic                  frame_end;

  // Round-robin pick: first pending channel at or above rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin : rr_select
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!sel_found && pending[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign sel_onehot = NUM_CH'(1) << sel_idx;

  // A launch decision is made only from IDLE and never under interlock; the
  // interlock gate matters in the very cycle it rises, before pending clears.
  assign launch_go = (state == ST_IDLE) && sel_found && !i_interlock;
  assign clr_mask  = launch_go ? sel_onehot : '0;

  // Completion needs a busy state first so a stale DONE left over from the
  // previous frame cannot end the new one early.
  assign done_hit  = (state == ST_WAIT_DONE) && busy_seen && (i_spi_state == SPI_DONE);
  assign frame_end = done_hit || timeout_hit;

  // Pending latch: starts set, launch clears the winner, interlock flushes all.
  // A start landing on the same cycle as its own launch survives as a new request.
  always_ff @(posedge i_clk) begin
    if (!i_fRST) begin
      pending <= '0;
    end else if (i_interlock) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | i_req_start;
    end
  end

  // Frame capture per channel; a repeated start simply overwrites the data.
  // NOTE: the data store has no reset -- it is only read for a channel whose
  // pending bit is set, and that bit is always written together with the data.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_req_start[c] && !i_interlock) begin
        data_q[c] <= i_req_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Main arbitration FSM: IDLE -> LAUNCH -> WAIT_DONE -> GAP -> IDLE.
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // here sees the pre-edge value of every other register.
  always_ff @(posedge i_clk) begin
    if (!i_fRST) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      busy_seen   <= 1'b0;
      gap_cnt     <= '0;
      o_spi_start <= 1'b0;
      o_spi_data  <= '0;
      o_grant     <= '0;
    end else begin
      o_spi_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_go) begin
            owner       <= sel_idx;
            o_grant     <= sel_onehot;
            o_spi_data  <= data_q[sel_idx];
            o_spi_start <= 1'b1;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          rr_ptr    <= (owner == LAST_CH) ? '0 : owner + 1'b1;
          busy_seen <= 1'b0;
          state     <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (frame_end) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else if (i_spi_state != SPI_IDLE && i_spi_state != SPI_DONE) begin
            busy_seen <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            o_grant <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DAC_ARB_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Watchdog: counts cycles in WAIT_DONE, restarting from zero each frame.
  always_ff @(posedge i_clk) begin
    if (!i_fRST) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT_DONE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT_DONE cycle unless a real done wins.
  assign timeout_hit = (state == ST_WAIT_DONE) && !done_hit && (wd_cnt == WD_LAST);
`else
  // Watchdog compiled out: this term is constant false for any legal limit,
  // so WAIT_DONE waits for the SPI master indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign o_timeout  = timeout_hit;
  assign o_busy     = (state != ST_IDLE);
  assign o_req_done = done_hit ? o_grant : '0;

  // Per-channel state view: only the owning channel sees the SPI master.
  always_comb begin
    o_req_state = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (o_grant[c]) begin
        o_req_state[c*3 +: 3] = i_spi_state;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// tb_dac_spi_arbiter
//
// Scoreboard bench for dac_spi_arbiter. Directed stimulus pushes the expected
// launches (owner, frame, cycle) and done pulses into queues; a monitor pops
// and compares whenever the DUT launches a frame or the SPI model completes
// one. The SPI model answers each launch with three busy cycles then one DONE
// cycle, or stays busy forever when hang mode is on.

module tb_dac_spi_arbiter;

  localparam int DW  = 24;
  localparam int NCH = 4;
  localparam int GAP = 30;
  localparam int TO  = 1023;

  logic               clk;
  logic               frst;
  logic [NCH-1:0]     req_start;
  logic [NCH*DW-1:0]  req_data;
  logic [NCH*3-1:0]   req_state;
  logic [NCH-1:0]     req_done;
  logic               interlock;
  logic               spi_start;
  logic [DW-1:0]      spi_data;
  logic [2:0]         spi_state;
  logic [NCH-1:0]     grant;
  logic               busy;
  logic               timeout;

  int cyc;
  int total;
  int passed;
  int model_done_cyc;
  bit spi_hang;

  typedef struct {
    logic [NCH-1:0] grant;
    logic [DW-1:0]  data;
    int             cyc;
    bit             rel;
  } launch_t;

  launch_t        exp_launch[$];
  logic [NCH-1:0] exp_done[$];

  dac_spi_arbiter #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_fRST(frst),
    .i_req_start(req_start),
    .i_req_data(req_data),
    .o_req_state(req_state),
    .o_req_done(req_done),
    .i_interlock(interlock),
    .o_spi_start(spi_start),
    .o_spi_data(spi_data),
    .i_spi_state(spi_state),
    .o_grant(grant),
    .o_busy(busy),
    .o_timeout(timeout)
  );

  // Clock; cyc is bumped just before each rising edge so cycle n starts there.
  initial begin : clkgen
    clk = 1'b0;
    cyc = 0;
    forever begin
      #5;
      cyc = cyc + 1;
      clk = 1'b1;
      #5;
      clk = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // SPI master model: launch seen in cycle L -> busy L+1..L+3, DONE in L+4.
  initial begin : spi_model
    bit st_s;
    int busy_left;
    bit pend_done;
    busy_left = 0;
    pend_done = 1'b0;
    spi_state = 3'd0;
    forever begin
      @(negedge clk);
      st_s = spi_start;
      @(posedge clk);
      #1;
      if (st_s) busy_left = 3;
      if (busy_left > 0) begin
        spi_state = 3'd2;
        busy_left--;
        pend_done = (busy_left == 0) && !spi_hang;
      end else if (pend_done) begin
        spi_state      = 3'd4;
        pend_done      = 1'b0;
        model_done_cyc = cyc;
      end else if (!spi_hang) begin
        spi_state = 3'd0;
      end
    end
  end

  // Monitor: compares each launch and each completion against the queues.
  initial begin : monitor
    launch_t e;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        if (exp_launch.size() == 0) begin
          check("launch_unexpected_grant", 64'(grant), 64'd0);
        end else begin
          e = exp_launch.pop_front();
          check("launch_grant", 64'(grant), 64'(e.grant));
          check("launch_data", 64'(spi_data), 64'(e.data));
          check("launch_cycle", 64'(cyc), e.rel ? 64'(model_done_cyc + GAP + 2) : 64'(e.cyc));
        end
      end
      if (spi_state == 3'd4) begin
        if (exp_done.size() == 0) check("done_unexpected", 64'(req_done), 64'd0);
        else check("done_owner", 64'(req_done), 64'(exp_done.pop_front()));
      end else if (req_done != '0) begin
        check("done_unexpected", 64'(req_done), 64'd0);
      end
    end
  end

  task automatic go_cyc(input int n);
    while (cyc < n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [NCH*DW-1:0] pack1(input int ch, input logic [DW-1:0] d);
    logic [NCH*DW-1:0] v;
    v = '0;
    v[ch*DW +: DW] = d;
    return v;
  endfunction

  // One-cycle start pulse; call at posedge+1, returns at the next posedge+1.
  task automatic drive_start(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] d);
    req_start = m;
    req_data  = d;
    @(posedge clk);
    #1;
    req_start = '0;
    req_data  = '0;
  endtask

  task automatic push_launch(input int ch, input logic [DW-1:0] d, input int c, input bit rel);
    launch_t e;
    e.grant = NCH'(1) << ch;
    e.data  = d;
    e.cyc   = c;
    e.rel   = rel;
    exp_launch.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_spi_start"}, 64'(spi_start), 64'd0);
    check({tag, "_spi_data"},  64'(spi_data),  64'd0);
    check({tag, "_grant"},     64'(grant),     64'd0);
    check({tag, "_req_done"},  64'(req_done),  64'd0);
    check({tag, "_req_state"}, 64'(req_state), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_timeout"},   64'(timeout),   64'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_launch.size() != 0 || exp_done.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'((busy ? 1 : 0) + exp_launch.size() + exp_done.size()), 64'd0);
  endtask

  task automatic wait_done(input string name, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (req_done == '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = (req_done != '0);
    check({name, "_seen"}, 64'(ok), 64'd1);
  endtask

  initial begin : stim
    int k;
    bit ok;
    total     = 0;
    passed    = 0;
    spi_hang  = 1'b0;
    model_done_cyc = 0;
    frst      = 1'b0;
    req_start = '0;
    req_data  = '0;
    interlock = 1'b0;

    // Reset state
    at_neg(2);
    check_all_zero("reset");
    go_cyc(3);
    frst = 1'b1;

    // Single request on channel 1
    go_cyc(6);
    k = cyc;
    push_launch(1, 24'h3A5F00, k + 2, 1'b0);
    exp_done.push_back(4'b0010);
    drive_start(4'b0010, pack1(1, 24'h3A5F00));
    at_neg(k + 1);
    check("single_idle_before_launch", 64'(busy), 64'd0);
    at_neg(k + 3);
    check("single_req_state_view", 64'(req_state), 64'h010);
    at_neg(k + 36);
    check("single_gap_last_busy", 64'(busy), 64'd1);
    check("single_gap_last_grant", 64'(grant), 64'b0010);
    at_neg(k + 37);
    check("single_idle_after_gap", 64'(busy), 64'd0);
    check("single_grant_cleared", 64'(grant), 64'd0);
    wait_idle("single");

    // Simultaneous starts on 0, 2, 3 straight after reset
    go_cyc(cyc + 1);
    frst = 1'b0;
    go_cyc(cyc + 2);
    frst = 1'b1;
    go_cyc(cyc + 2);
    k = cyc;
    push_launch(0, 24'hA00000, k + 2, 1'b0);
    push_launch(2, 24'hA22222, 0, 1'b1);
    push_launch(3, 24'hA33333, 0, 1'b1);
    exp_done.push_back(4'b0001);
    exp_done.push_back(4'b0100);
    exp_done.push_back(4'b1000);
    drive_start(4'b1101, pack1(0, 24'hA00000) | pack1(2, 24'hA22222) | pack1(3, 24'hA33333));
    wait_idle("simul");

    // Fairness: channels 0 and 1 re-request on every done, 8 frames
    go_cyc(cyc + 2);
    k = cyc;
    for (int i = 0; i < 8; i++) begin
      push_launch(i % 2, 24'hF00000 + 24'(i), k + 2, i != 0);
      exp_done.push_back(NCH'(1) << (i % 2));
    end
    drive_start(4'b0011, pack1(0, 24'hF00000) | pack1(1, 24'hF00001));
    for (int i = 0; i < 8; i++) begin
      wait_done("fair_done", ok);
      if (!ok) break;
      if (i < 6) begin
        go_cyc(cyc + 1);
        drive_start(NCH'(1) << (i % 2), pack1(i % 2, 24'hF00000 + 24'(i + 2)));
      end
    end
    wait_idle("fair");

    // Overwrite: channel 2 re-started while the bus is busy -> one frame, latest data
    go_cyc(cyc + 2);
    k = cyc;
    push_launch(0, 24'h0A0A0A, k + 2, 1'b0);
    push_launch(2, 24'h222222, 0, 1'b1);
    exp_done.push_back(4'b0001);
    exp_done.push_back(4'b0100);
    drive_start(4'b0001, pack1(0, 24'h0A0A0A));
    drive_start(4'b0100, pack1(2, 24'h111111));
    go_cyc(k + 4);
    drive_start(4'b0100, pack1(2, 24'h222222));
    wait_idle("overwrite");

    // Interlock mid-WAIT_DONE with channel 3 pending
    go_cyc(cyc + 2);
    k = cyc;
    push_launch(0, 24'h0B0B0B, k + 2, 1'b0);
    exp_done.push_back(4'b0001);
    drive_start(4'b0001, pack1(0, 24'h0B0B0B));
    drive_start(4'b1000, pack1(3, 24'h0C0C0C));
    go_cyc(k + 4);
    interlock = 1'b1;
    go_cyc(k + 10);
    drive_start(4'b0010, pack1(1, 24'h0D0D0D));
    go_cyc(k + 45);
    drive_start(4'b0100, pack1(2, 24'h0D0D0E));
    at_neg(k + 50);
    check("interlock_held_idle", 64'(busy), 64'd0);
    check("interlock_no_grant", 64'(grant), 64'd0);
    go_cyc(k + 70);
    interlock = 1'b0;
    at_neg(k + 120);
    check("interlock_flushed", 64'(busy), 64'd0);
    wait_idle("interlock");

`ifdef DAC_ARB_TIMEOUT_EN
    // Watchdog: SPI never reaches DONE
    spi_hang = 1'b1;
    go_cyc(cyc + 2);
    k = cyc;
    push_launch(1, 24'h0E0E0E, k + 2, 1'b0);
    drive_start(4'b0010, pack1(1, 24'h0E0E0E));
    at_neg(k + 1024);
    check("timeout_not_early", 64'(timeout), 64'd0);
    at_neg(k + 1025);
    check("timeout_pulse", 64'(timeout), 64'd1);
    at_neg(k + 1026);
    check("timeout_one_cycle", 64'(timeout), 64'd0);
    check("timeout_in_gap", 64'(busy), 64'd1);
    at_neg(k + 1056);
    check("timeout_back_idle", 64'(busy), 64'd0);
    spi_hang = 1'b0;
    wait_idle("timeout");
`endif

    // Reset asserted mid-frame drops the transaction silently
    spi_hang = 1'b1;
    go_cyc(cyc + 2);
    k = cyc;
    push_launch(2, 24'h0F0F0F, k + 2, 1'b0);
    drive_start(4'b0100, pack1(2, 24'h0F0F0F));
    go_cyc(k + 5);
    frst = 1'b0;
    at_neg(k + 6);
    check_all_zero("midreset");
    go_cyc(k + 7);
    frst = 1'b1;
    spi_hang = 1'b0;
    at_neg(k + 60);
    check("midreset_stays_idle", 64'(busy), 64'd0);
    check("final_queues_empty", 64'(exp_launch.size() + exp_done.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
